// File: rtl/regbridge_pkg.sv
// Shared types and constants for the serial register-file bridge.
// Optional feature: define REGBRIDGE_PARITY_EN to add one odd-parity bit at the frame MSB.
// Frame layout, LSB first: op | addr | data | (parity).
package regbridge_pkg;

    localparam int unsigned DATA_W   = 8;
    localparam int unsigned ADDR_W   = 3;
    localparam int unsigned OP_POS   = 0;
    localparam int unsigned ADDR_LSB = 1;
    localparam int unsigned DATA_LSB = 1 + ADDR_W;
    localparam int unsigned CMD_W    = 1 + ADDR_W + DATA_W;

`ifdef REGBRIDGE_PARITY_EN
    localparam int unsigned PAR_W = 1;
`else
    localparam int unsigned PAR_W = 0;
`endif

    localparam int unsigned FRAME_W = CMD_W + PAR_W;
    // Counter saturates at FRAME_W+1, so it must hold that value.
    localparam int unsigned CNT_W   = $clog2(FRAME_W + 2);

    localparam logic OP_READ  = 1'b0;
    localparam logic OP_WRITE = 1'b1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        EXEC  = 2'd2
    } state_t;

    // Decoded command payload (without parity bit).
    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [ADDR_W-1:0] addr;
        logic              op;
    } cmd_t;

    // Frame integrity: odd parity over the whole frame when parity is built in.
    function automatic logic frame_ok(input logic [FRAME_W-1:0] frame);
        return (PAR_W == 0) || (^frame == 1'b1);
    endfunction

endpackage

// File: rtl/regbridge_shifter.sv
// Serial datapath: input frame shift register, output capture/shift register and
// saturating received-bit counter.
// Ports:
//   clk, srst            clock, async active-high reset
//   shift_en             accept one serial bit this cycle
//   sdi                  serial bit entering in_sr at the MSB
//   cnt_clr              restart bit_cnt (the bit accepted in the same cycle still counts)
//   load_en, load_data   parallel load of out_sr (wins over shifting)
//   in_sr, out_sr        shift register contents
//   bit_cnt              bits received in the current frame, saturating at FRAME_W+1
module regbridge_shifter
    import regbridge_pkg::*;
(
    input  logic               clk,
    input  logic               srst,
    input  logic               shift_en,
    input  logic               sdi,
    input  logic               cnt_clr,
    input  logic               load_en,
    input  logic [DATA_W-1:0]  load_data,
    output logic [FRAME_W-1:0] in_sr,
    output logic [DATA_W-1:0]  out_sr,
    output logic [CNT_W-1:0]   bit_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(FRAME_W + 1);

    always_ff @(posedge clk or posedge srst) begin
        if (srst) begin
            in_sr   <= '0;
            out_sr  <= '0;
            bit_cnt <= '0;
        end else begin
            if (shift_en) begin
                in_sr <= {sdi, in_sr[FRAME_W-1:1]};
            end

            if (load_en) begin
                out_sr <= load_data;
            end else if (shift_en) begin
                out_sr <= {1'b0, out_sr[DATA_W-1:1]};
            end

            if (cnt_clr) begin
                bit_cnt <= shift_en ? CNT_W'(1) : '0;
            end else if (shift_en && (bit_cnt != CNT_MAX)) begin
                bit_cnt <= bit_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/regfile_scan_bridge.sv
// Serial-to-parallel command bridge in front of the 8x8 register file. Each serial frame
// becomes one register write or read; the written/read byte shifts out on sdo during the
// next frame. Optional feature macro: REGBRIDGE_PARITY_EN (odd-parity frame check).
// Ports:
//   clk, srst                 clock, async active-high reset
//   scan_en, sdi, sdi_valid   frame window and qualified serial input, LSB first
//   sdo                       serial output (out_sr LSB)
//   reg_write, w_addr, w_data register-file write port
//   r_addr, r_data            register-file read port (r_data combinational)
//   busy                      bridge not idle
//   frame_err                 one-cycle malformed-frame pulse
module regfile_scan_bridge
    import regbridge_pkg::*;
(
    input  logic              clk,
    input  logic              srst,
    input  logic              scan_en,
    input  logic              sdi,
    input  logic              sdi_valid,
    output logic              sdo,
    output logic              reg_write,
    output logic [ADDR_W-1:0] w_addr,
    output logic [DATA_W-1:0] w_data,
    output logic [ADDR_W-1:0] r_addr,
    input  logic [DATA_W-1:0] r_data,
    output logic              busy,
    output logic              frame_err
);

    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_W);

    state_t             state;
    state_t             state_next;
    logic [FRAME_W-1:0] in_sr;
    logic [DATA_W-1:0]  out_sr;
    logic [CNT_W-1:0]   bit_cnt;
    cmd_t               cmd;
    logic               good;
    logic               shift_en;
    logic               cnt_clr;
    logic               load_en;
    logic [DATA_W-1:0]  load_data;
    logic               reg_write_d;
    logic               frame_err_d;
    logic [ADDR_W-1:0]  w_addr_d;
    logic [DATA_W-1:0]  w_data_d;
    logic [ADDR_W-1:0]  r_addr_d;

    assign cmd  = cmd_t'(in_sr[CMD_W-1:0]);
    assign good = frame_ok(in_sr);

    // Bits arriving during EXEC are dropped.
    assign shift_en = scan_en && sdi_valid && (state != EXEC);
    assign cnt_clr  = (state == IDLE);
    assign sdo      = out_sr[0];

    regbridge_shifter u_shifter (
        .clk       (clk),
        .srst      (srst),
        .shift_en  (shift_en),
        .sdi       (sdi),
        .cnt_clr   (cnt_clr),
        .load_en   (load_en),
        .load_data (load_data),
        .in_sr     (in_sr),
        .out_sr    (out_sr),
        .bit_cnt   (bit_cnt)
    );

    // State register.
    always_ff @(posedge clk or posedge srst) begin
        if (srst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (scan_en) state_next = SHIFT;
            SHIFT:   if (!scan_en) state_next = (bit_cnt == CNT_FULL) ? EXEC : IDLE;
            EXEC:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Output/decode logic: port values are registered on entry to EXEC so they are
    // stable for the whole EXEC cycle; out_sr captures at the end of EXEC so the
    // combinational r_data has settled for the registered r_addr.
    always_comb begin
        reg_write_d = 1'b0;
        frame_err_d = 1'b0;
        w_addr_d    = w_addr;
        w_data_d    = w_data;
        r_addr_d    = r_addr;
        load_en     = 1'b0;
        load_data   = cmd.data;

        if ((state == SHIFT) && !scan_en) begin
            if ((bit_cnt == CNT_FULL) && good) begin
                if (cmd.op == OP_WRITE) begin
                    reg_write_d = 1'b1;
                    w_addr_d    = cmd.addr;
                    w_data_d    = cmd.data;
                end else begin
                    r_addr_d    = cmd.addr;
                end
            end else begin
                frame_err_d = 1'b1;
            end
        end

        if (state == EXEC) begin
            if (good) begin
                load_en   = 1'b1;
                load_data = (cmd.op == OP_WRITE) ? cmd.data : r_data;
            end
            if (scan_en) begin
                frame_err_d = 1'b1;
            end
        end
    end

    // Output registers.
    always_ff @(posedge clk or posedge srst) begin
        if (srst) begin
            reg_write <= 1'b0;
            frame_err <= 1'b0;
            w_addr    <= '0;
            w_data    <= '0;
            r_addr    <= '0;
            busy      <= 1'b0;
        end else begin
            reg_write <= reg_write_d;
            frame_err <= frame_err_d;
            w_addr    <= w_addr_d;
            w_data    <= w_data_d;
            r_addr    <= r_addr_d;
            busy      <= (state_next != IDLE);
        end
    end

endmodule
